tcu_tile_mac: RTL and testbench

Tile matrix-multiply engine for the tensor core. It sits directly downstream of the TCU issue/sequencing stage, which streams operand tiles A and B in one element pair per cycle, and it returns the product tile C word-serially for write-back to CSR/LSU. Computation is a single sequential MAC datapath: C = A×B over a TILE_N×TILE_N tile, with load, execute and store phases under one FSM and pulse handshakes to the sequencer.

---
 rtl/tcu_tile_mac.sv | 147 ++++++++++++++
 tb/tb_tcu_tile_mac.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_tile_mac.sv
// tcu_tile_mac: sequential TILE_N x TILE_N tile MAC engine (C = A x B).
// Build option: define TCU_ACCUM_EN to accumulate C across operations.
module tcu_tile_mac #(
  parameter int TILE_N = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(TILE_N*TILE_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_in_b,
  output logic              load_done,
  output logic              execute_done,
  input  logic              store_start,
  output logic [DATA_W-1:0] data_out_c,
  output logic              store_valid,
  output logic              store_done,
  output logic [IDX_W-1:0]  elem_idx,
`ifdef TCU_ACCUM_EN
  input  logic              acc_clear,
`endif
  output logic              busy
);

  localparam int NN    = TILE_N * TILE_N;
  localparam int CW    = $clog2(TILE_N);
  localparam int CNT_W = 3 * CW;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NN - 1);
  localparam logic [IDX_W-1:0] LAST_M1 = IDX_W'(NN - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_READY,
    S_STORE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NN-1:0][DATA_W-1:0] a_mem;
  logic [NN-1:0][DATA_W-1:0] b_mem;
  logic [NN-1:0][DATA_W-1:0] c_mem;

  // {i, j, k}: k innermost, then j, then i
  logic [CNT_W-1:0]  cnt;
  logic [CW-1:0]     mi;
  logic [CW-1:0]     mj;
  logic [CW-1:0]     mk;
  logic [IDX_W-1:0]  a_addr;
  logic [IDX_W-1:0]  b_addr;
  logic [IDX_W-1:0]  c_addr;
  logic [DATA_W-1:0] prod;
  logic [IDX_W-1:0]  nxt_idx;
  logic              idx_last;
  logic              mac_last;
  logic              st_go;

  assign mi       = cnt[3*CW-1:2*CW];
  assign mj       = cnt[2*CW-1:CW];
  assign mk       = cnt[CW-1:0];
  assign a_addr   = IDX_W'({mi, mk});
  assign b_addr   = IDX_W'({mk, mj});
  assign c_addr   = IDX_W'({mi, mj});
  assign prod     = a_mem[a_addr] * b_mem[b_addr];
  assign nxt_idx  = elem_idx + IDX_W'(1);
  assign idx_last = (elem_idx == LAST);
  assign mac_last = (cnt == {CNT_W{1'b1}});
  assign st_go    = (state == S_READY) && store_start;
  assign busy     = (state == S_LOAD) || (state == S_EXEC) ||
                    (state == S_STORE);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (load_start)  state_nx = S_LOAD;
      S_LOAD:  if (idx_last)    state_nx = S_EXEC;
      S_EXEC:  if (mac_last)    state_nx = S_READY;
      S_READY: if (store_start) state_nx = S_STORE;
      S_STORE: if (idx_last)    state_nx = S_IDLE;
      default:                  state_nx = S_IDLE;
    endcase
  end

  // handshake pulses, element index, MAC counter, store beat register
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_done    <= 1'b0;
      execute_done <= 1'b0;
      store_valid  <= 1'b0;
      store_done   <= 1'b0;
      elem_idx     <= '0;
      data_out_c   <= '0;
      cnt          <= '0;
    end else begin
      load_done    <= (state == S_LOAD) && idx_last;
      execute_done <= (state == S_EXEC) && mac_last;
      store_valid  <= st_go || ((state == S_STORE) && !idx_last);
      store_done   <= (state == S_STORE) && (elem_idx == LAST_M1);
      cnt          <= (state == S_EXEC) ? cnt + CNT_W'(1) : '0;
      if ((state == S_LOAD) || (state == S_STORE))
        elem_idx <= nxt_idx;
      else if (st_go || ((state == S_IDLE) && load_start))
        elem_idx <= '0;
      if (st_go)
        data_out_c <= c_mem[0];
      else if ((state == S_STORE) && !idx_last)
        data_out_c <= c_mem[nxt_idx];
      else
        data_out_c <= '0;
    end
  end

  // operand capture, only while loading
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      a_mem[elem_idx] <= data_in_a;
      b_mem[elem_idx] <= data_in_b;
    end
  end

  // result tile: clear, then one wrapping MAC per EXEC cycle
  always_ff @(posedge clk) begin
    if (!reset)
      c_mem <= '0;
    else if (state == S_EXEC)
      c_mem[c_addr] <= c_mem[c_addr] + prod;
`ifdef TCU_ACCUM_EN
    else if (((state == S_IDLE) || (state == S_READY)) && acc_clear)
      c_mem <= '0;
`else
    else if ((state == S_LOAD) && idx_last)
      c_mem <= '0;
`endif
  end

endmodule

// File: tb/tb_tcu_tile_mac.sv
// tb_tcu_tile_mac: directed + random checks of tcu_tile_mac, N=2 and N=4.
// Reference model is a plain matrix product with 32-bit wrap.
module tb_tcu_tile_mac;

  typedef logic [31:0] tile_t [16];

`ifdef TCU_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_start;
  logic        store_start;
  logic        use4;
  logic [31:0] a_in;
  logic [31:0] b_in;
`ifdef TCU_ACCUM_EN
  logic        acc_clear;
`endif

  logic        ls2, ls4, ss2, ss4;
  logic        ld2, ed2, sv2, sd2, bz2;
  logic        ld4, ed4, sv4, sd4, bz4;
  logic [31:0] dc2, dc4;
  logic [1:0]  ei2;
  logic [3:0]  ei4;

  logic        o_ld, o_ed, o_sv, o_sd, o_bz;
  logic [31:0] o_dc;
  logic [3:0]  o_ei;

  assign ls2 = load_start & ~use4;
  assign ls4 = load_start & use4;
  assign ss2 = store_start & ~use4;
  assign ss4 = store_start & use4;

  assign o_ld = use4 ? ld4 : ld2;
  assign o_ed = use4 ? ed4 : ed2;
  assign o_sv = use4 ? sv4 : sv2;
  assign o_sd = use4 ? sd4 : sd2;
  assign o_bz = use4 ? bz4 : bz2;
  assign o_dc = use4 ? dc4 : dc2;
  assign o_ei = use4 ? ei4 : {2'b00, ei2};

  tcu_tile_mac #(.TILE_N(2), .DATA_W(32)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .load_start   (ls2),
    .data_in_a    (a_in),
    .data_in_b    (b_in),
    .load_done    (ld2),
    .execute_done (ed2),
    .store_start  (ss2),
    .data_out_c   (dc2),
    .store_valid  (sv2),
    .store_done   (sd2),
    .elem_idx     (ei2),
`ifdef TCU_ACCUM_EN
    .acc_clear    (acc_clear & ~use4),
`endif
    .busy         (bz2)
  );

  tcu_tile_mac #(.TILE_N(4), .DATA_W(32)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .load_start   (ls4),
    .data_in_a    (a_in),
    .data_in_b    (b_in),
    .load_done    (ld4),
    .execute_done (ed4),
    .store_start  (ss4),
    .data_out_c   (dc4),
    .store_valid  (sv4),
    .store_done   (sd4),
    .elem_idx     (ei4),
`ifdef TCU_ACCUM_EN
    .acc_clear    (acc_clear & use4),
`endif
    .busy         (bz4)
  );

  int    vectors = 0;
  int    miscompares = 0;
  tile_t acc_m [2];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int e = 0; e < 16; e++) acc_m[d][e] = 32'h0;
  endtask

  // C = A x B (or C += A x B when accumulating), wrapping at 32 bits
  task automatic model_op(input tile_t a, input tile_t b);
    int n;
    int d;
    logic [31:0] s;
    n = use4 ? 4 : 2;
    d = use4 ? 1 : 0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 32'h0;
        for (int k = 0; k < n; k++)
          s = s + a[i*n+k] * b[k*n+j];
        acc_m[d][i*n+j] = ACC ? acc_m[d][i*n+j] + s : s;
      end
  endtask

  task automatic do_load(input tile_t a, input tile_t b, input bit poke);
    int n;
    int cyc;
    n = use4 ? 4 : 2;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("busy_in_load", {31'b0, o_bz}, 32'd1);
    for (int e = 0; e < n*n; e++) begin
      a_in = a[e];
      b_in = b[e];
      chk($sformatf("load_idx[%0d]", e), {28'b0, o_ei}, e);
      tick;
    end
    chk("load_done_pulse", {31'b0, o_ld}, 32'd1);
    cyc = 0;
    while (!o_ed && cyc < 1000) begin
      load_start = poke && (cyc == 2);
      tick;
      cyc++;
    end
    load_start = 1'b0;
    chk("exec_cycles", cyc, n*n*n);
    chk("busy_in_ready", {31'b0, o_bz}, 32'd0);
    chk("no_load_done_ready", {31'b0, o_ld}, 32'd0);
  endtask

  task automatic do_store(input tile_t exp, input string tag);
    int n;
    n = use4 ? 4 : 2;
    store_start = 1'b1;
    tick;
    store_start = 1'b0;
    for (int e = 0; e < n*n; e++) begin
      chk($sformatf("%s_valid[%0d]", tag, e), {31'b0, o_sv}, 32'd1);
      chk($sformatf("%s_c[%0d]", tag, e), o_dc, exp[e]);
      chk($sformatf("%s_idx[%0d]", tag, e), {28'b0, o_ei}, e);
      chk($sformatf("%s_done[%0d]", tag, e), {31'b0, o_sd},
          (e == n*n-1) ? 32'd1 : 32'd0);
      tick;
    end
    chk({tag, "_valid_end"}, {31'b0, o_sv}, 32'd0);
    chk({tag, "_busy_end"}, {31'b0, o_bz}, 32'd0);
  endtask

  task automatic run(input tile_t a, input tile_t b, input string tag);
    do_load(a, b, 1'b0);
    model_op(a, b);
    do_store(acc_m[use4 ? 1 : 0], tag);
  endtask

  tile_t ba, bb, bc, wa, wb, ra, rb, zt, ia, ib, ic;
  int    ed_seen;

  initial begin
    reset = 1'b0;
    load_start = 1'b0;
    store_start = 1'b0;
    use4 = 1'b0;
    a_in = 32'h0;
    b_in = 32'h0;
`ifdef TCU_ACCUM_EN
    acc_clear = 1'b0;
`endif
    ba = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bb = '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bc = '{19, 22, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    wa = '{32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    wb = '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int e = 0; e < 16; e++) begin
      zt[e] = 32'h0;
      ia[e] = ((e / 4) == (e % 4)) ? 32'd1 : 32'd0;
      ib[e] = e + 1;
      ic[e] = e + 1;
    end
    model_clear(0);
    model_clear(1);
    repeat (3) tick;

    for (int d = 0; d < 2; d++) begin
      use4 = d[0];
      chk("rst_busy", {31'b0, o_bz}, 32'd0);
      chk("rst_valid", {31'b0, o_sv}, 32'd0);
      chk("rst_done", {29'b0, o_ld, o_ed, o_sd}, 32'd0);
      chk("rst_idx", {28'b0, o_ei}, 32'd0);
      chk("rst_data", o_dc, 32'd0);
    end
    use4 = 1'b0;
    reset = 1'b1;
    tick;

    do_load(ba, bb, 1'b0);
    model_op(ba, bb);
    do_store(bc, "basic");

    store_start = 1'b1;
    tick;
    store_start = 1'b0;
    chk("idle_sst_busy", {31'b0, o_bz}, 32'd0);
    chk("idle_sst_valid", {31'b0, o_sv}, 32'd0);
    tick;
    chk("idle_sst_valid2", {31'b0, o_sv}, 32'd0);

    if (!ACC) begin
      do_load(wa, wb, 1'b0);
      model_op(wa, wb);
      do_store('{32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 0}, "wrap");
    end else begin
      run(wa, wb, "wrap");
    end

    do_load(ba, bb, 1'b1);
    model_op(ba, bb);
    do_store(acc_m[0], "poke");

    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      a_in = ba[e];
      b_in = bb[e];
      tick;
    end
    tick;
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    model_clear(0);
    model_clear(1);
    chk("mid_rst_busy", {31'b0, o_bz}, 32'd0);
    chk("mid_rst_valid", {31'b0, o_sv}, 32'd0);
    chk("mid_rst_idx", {28'b0, o_ei}, 32'd0);
    ed_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (o_ed || o_sv || o_ld) ed_seen++;
      tick;
    end
    chk("mid_rst_no_pulse", ed_seen, 32'd0);
    do_load(ba, bb, 1'b0);
    model_op(ba, bb);
    do_store(bc, "after_rst");

`ifdef TCU_ACCUM_EN
    do_load(ba, bb, 1'b0);
    model_op(ba, bb);
    do_store('{38, 44, 86, 100, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0, 0}, "accum2");
    do_load(ba, bb, 1'b0);
    acc_clear = 1'b1;
    tick;
    acc_clear = 1'b0;
    model_clear(0);
    do_store(zt, "cleared");
    do_load(ba, bb, 1'b0);
    model_op(ba, bb);
    do_store(bc, "after_clear");
`else
    do_load(ba, bb, 1'b0);
    model_op(ba, bb);
    do_store(bc, "second");
`endif

    for (int r = 0; r < 3; r++) begin
      for (int e = 0; e < 16; e++) begin
        ra[e] = (r == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        rb[e] = (r == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      end
      run(ra, rb, $sformatf("rand2_%0d", r));
    end

    use4 = 1'b1;
    do_load(ia, ib, 1'b0);
    model_op(ia, ib);
    do_store(ic, "n4_ident");
    for (int e = 0; e < 16; e++) begin
      ra[e] = $urandom;
      rb[e] = $urandom;
    end
    run(ra, rb, "rand4");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
